// File: rtl/nfc_ram_arb.sv
// Page-buffer RAM arbiter: MIF, ECC read-modify-write correction and host share one single-port RAM.
// Grants are combinational, the host read completes one cycle after grant, and losers retry by holding their request.
module nfc_ram_arb #(
    parameter int HST_MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mif_req,
    input  logic [12:0] mif_addr,
    input  logic [1:0]  mif_wen,
    input  logic [15:0] mif_din,
    output logic        mif_gnt,
    output logic [15:0] mif_dout,
    input  logic        ecc_fix_req,
    input  logic [12:0] ecc_fix_addr,
    input  logic [15:0] ecc_fix_mask,
    output logic        ecc_fix_done,
    input  logic        hst_req,
    input  logic        hst_wr,
    input  logic [12:0] hst_addr,
    input  logic [1:0]  hst_be,
    input  logic [15:0] hst_wdat,
    output logic        hst_rdy,
    output logic [15:0] hst_rdat,
    output logic [12:0] ram_addr,
    output logic        ram_cen,
    output logic [1:0]  ram_wen,
    output logic [15:0] ram_din,
    input  logic [15:0] ram_dout
);

    typedef enum logic [2:0] {FIX_IDLE, FIX_RD, FIX_WAIT, FIX_WR, FIX_DONE} fix_state_t;

    localparam logic [3:0] MAX_WAIT = 4'(HST_MAX_WAIT);

    fix_state_t  state, state_nxt;
    logic [3:0]  wait_cnt, wait_nxt;
    logic [15:0] fix_buf;
    logic        rd_pend;

    logic ecc_lock, hst_ok, hst_ovr, mif_g, ecc_rd_g, ecc_wr_g, hst_gnt;

    // The host may not be re-granted while its previous read is returning data.
    assign ecc_lock = (state == FIX_WAIT) || (state == FIX_WR);
    assign hst_ok   = hst_req && !rd_pend;
    assign hst_ovr  = hst_ok && (wait_cnt == MAX_WAIT) && !ecc_lock;
    assign mif_g    = rst_n && mif_req && !hst_ovr && !ecc_lock;
    assign ecc_rd_g = rst_n && (state == FIX_RD) && !hst_ovr && !mif_req;
    assign ecc_wr_g = rst_n && (state == FIX_WR);
    assign hst_gnt  = rst_n && hst_ok && !ecc_lock &&
                      (hst_ovr || (!mif_req && (state != FIX_RD)));

    assign mif_gnt      = mif_g;
    assign mif_dout     = ram_dout;
    assign ecc_fix_done = (state == FIX_DONE);
    assign hst_rdy      = (hst_gnt && hst_wr) || rd_pend;
    assign hst_rdat     = rd_pend ? ram_dout : 16'h0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FIX_IDLE;
            wait_cnt <= 4'd0;
            fix_buf  <= 16'h0000;
            rd_pend  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            rd_pend  <= hst_gnt && !hst_wr;
            if (state == FIX_WAIT) begin
                fix_buf <= ram_dout;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FIX_IDLE: if (ecc_fix_req) state_nxt = FIX_RD;
            FIX_RD:   if (ecc_rd_g) state_nxt = FIX_WAIT;
            FIX_WAIT: state_nxt = FIX_WR;
            FIX_WR:   state_nxt = FIX_DONE;
            FIX_DONE: state_nxt = FIX_IDLE;
            default:  state_nxt = FIX_IDLE;
        endcase
    end

    // The returning-read cycle is not counted as waiting: the request is completing.
    always_comb begin
        wait_nxt = 4'd0;
        if (hst_ok && !hst_gnt) begin
            wait_nxt = (wait_cnt == MAX_WAIT) ? wait_cnt : wait_cnt + 4'd1;
        end
    end

    always_comb begin
        ram_cen  = 1'b1;
        ram_wen  = 2'b11;
        ram_addr = 13'd0;
        ram_din  = 16'h0000;
        if (mif_g) begin
            ram_cen  = 1'b0;
            ram_wen  = mif_wen;
            ram_addr = mif_addr;
            ram_din  = mif_din;
        end else if (ecc_rd_g) begin
            ram_cen  = 1'b0;
            ram_addr = ecc_fix_addr;
        end else if (ecc_wr_g) begin
            ram_cen  = 1'b0;
            ram_wen  = 2'b00;
            ram_addr = ecc_fix_addr;
            ram_din  = fix_buf ^ ecc_fix_mask;
        end else if (hst_gnt) begin
            ram_cen  = 1'b0;
            ram_wen  = hst_wr ? ~hst_be : 2'b11;
            ram_addr = hst_addr;
            ram_din  = hst_wdat;
        end
    end

endmodule

// File: tb/tb_nfc_ram_arb.sv
// Bench for nfc_ram_arb: behavioural single-port RAM plus scenario tasks with a queue of expected data.
module tb_nfc_ram_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mif_req;
    logic [12:0] mif_addr;
    logic [1:0]  mif_wen;
    logic [15:0] mif_din;
    logic        mif_gnt;
    logic [15:0] mif_dout;
    logic        ecc_fix_req;
    logic [12:0] ecc_fix_addr;
    logic [15:0] ecc_fix_mask;
    logic        ecc_fix_done;
    logic        hst_req, hst_wr;
    logic [12:0] hst_addr;
    logic [1:0]  hst_be;
    logic [15:0] hst_wdat;
    logic        hst_rdy;
    logic [15:0] hst_rdat;
    logic [12:0] ram_addr;
    logic        ram_cen;
    logic [1:0]  ram_wen;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;

    logic [15:0] mem [0:8191];
    logic        pl_en = 1'b0;
    logic [12:0] pl_addr = 13'd0;
    logic [15:0] pl_dat = 16'h0000;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    nfc_ram_arb #(.HST_MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mif_req(mif_req), .mif_addr(mif_addr), .mif_wen(mif_wen), .mif_din(mif_din),
        .mif_gnt(mif_gnt), .mif_dout(mif_dout),
        .ecc_fix_req(ecc_fix_req), .ecc_fix_addr(ecc_fix_addr), .ecc_fix_mask(ecc_fix_mask),
        .ecc_fix_done(ecc_fix_done),
        .hst_req(hst_req), .hst_wr(hst_wr), .hst_addr(hst_addr), .hst_be(hst_be),
        .hst_wdat(hst_wdat), .hst_rdy(hst_rdy), .hst_rdat(hst_rdat),
        .ram_addr(ram_addr), .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_dat;
        end else if (!ram_cen) begin
            if (ram_wen == 2'b11) begin
                ram_dout <= mem[ram_addr];
            end else begin
                if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
                if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
            end
        end
    end

    function automatic logic [15:0] mif_val(input int i);
        return 16'h1000 + 16'(i) * 16'h0111;
    endfunction

    task automatic preload(input logic [12:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_dat = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        mif_req = 1'b1; mif_addr = 13'h1abc; mif_wen = 2'b00; mif_din = 16'hffff;
        ecc_fix_req = 1'b1; ecc_fix_addr = 13'h0123; ecc_fix_mask = 16'hffff;
        hst_req = 1'b1; hst_wr = 1'b1; hst_addr = 13'h1fff; hst_be = 2'b11; hst_wdat = 16'hffff;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (mif_gnt !== 1'b0) begin failures++; $display("FAIL reset_mif_gnt got=%b exp=0", mif_gnt); end
        checks++;
        if (ram_cen !== 1'b1 || ram_wen !== 2'b11) begin
            failures++; $display("FAIL reset_ram_ctl got cen=%b wen=%b exp cen=1 wen=11", ram_cen, ram_wen);
        end
        checks++;
        if (ram_addr !== 13'd0 || ram_din !== 16'h0000) begin
            failures++; $display("FAIL reset_ram_bus got addr=%h din=%h exp 0/0", ram_addr, ram_din);
        end
        checks++;
        if (hst_rdy !== 1'b0 || hst_rdat !== 16'h0000 || ecc_fix_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_status got rdy=%b rdat=%h done=%b exp 0/0000/0", hst_rdy, hst_rdat, ecc_fix_done);
        end
        mif_req = 1'b0; ecc_fix_req = 1'b0; hst_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mif_reads;
        logic [15:0] got;
        for (int i = 0; i < 8; i++) preload(13'(i), mif_val(i));
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i < 8) begin
                mif_req = 1'b1; mif_addr = 13'(i); mif_wen = 2'b11;
            end else begin
                mif_req = 1'b0;
            end
            #1;
            if (i > 0) begin
                got = exp_q.pop_front();
                checks++;
                if (mif_dout !== got) begin failures++; $display("FAIL mif_rd_data idx=%0d got=%h exp=%h", i - 1, mif_dout, got); end
            end
            if (i < 8) begin
                checks++;
                if (mif_gnt !== 1'b1 || ram_cen !== 1'b0 || ram_addr !== 13'(i)) begin
                    failures++; $display("FAIL mif_rd_gnt idx=%0d got gnt=%b addr=%h exp gnt=1 addr=%h", i, mif_gnt, ram_addr, 13'(i));
                end
                exp_q.push_back(mif_val(i));
            end
        end
    endtask

    task automatic test_ecc_fix;
        logic [15:0] got;
        bit found;
        preload(13'h123, 16'h00a5);
        @(negedge clk);
        ecc_fix_req = 1'b1; ecc_fix_addr = 13'h123; ecc_fix_mask = 16'h0004;
        exp_q.push_back(16'h00a1);
        found = 1'b0;
        for (int n = 0; n < 8; n++) begin
            #1;
            if (ram_cen === 1'b0 && ram_addr === 13'h123 && ram_wen === 2'b11) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!found) begin failures++; $display("FAIL ecc_rd_gnt got=none exp=read of 0123"); exp_q.delete(); ecc_fix_req = 1'b0; return; end
        @(negedge clk); #1;
        checks++;
        if (ram_cen !== 1'b1) begin failures++; $display("FAIL ecc_wait_idle got cen=%b exp=1", ram_cen); end
        @(negedge clk); #1;
        got = exp_q.pop_front();
        checks++;
        if (ram_cen !== 1'b0 || ram_wen !== 2'b00 || ram_addr !== 13'h123 || ram_din !== got) begin
            failures++; $display("FAIL ecc_write got cen=%b wen=%b addr=%h din=%h exp 0/00/0123/%h", ram_cen, ram_wen, ram_addr, ram_din, got);
        end
        @(negedge clk); #1;
        checks++;
        if (ecc_fix_done !== 1'b1) begin failures++; $display("FAIL ecc_done_pulse got=%b exp=1", ecc_fix_done); end
        @(negedge clk);
        ecc_fix_req = 1'b0;
        #1;
        checks++;
        if (ecc_fix_done !== 1'b0 || mem[13'h123] !== 16'h00a1) begin
            failures++; $display("FAIL ecc_result got done=%b ram=%h exp 0/00a1", ecc_fix_done, mem[13'h123]);
        end
    endtask

    task automatic test_ecc_mif_conflict;
        logic [15:0] got;
        preload(13'h200, 16'hffff);
        @(negedge clk);
        ecc_fix_req = 1'b1; ecc_fix_addr = 13'h200; ecc_fix_mask = 16'h8001;
        mif_req = 1'b1; mif_addr = 13'h005; mif_wen = 2'b11;
        exp_q.push_back(16'h7ffe);
        #1;
        checks++;
        if (mif_gnt !== 1'b1) begin failures++; $display("FAIL conflict_idle_mif got=%b exp=1", mif_gnt); end
        @(negedge clk); #1;
        checks++;
        if (mif_gnt !== 1'b1 || ram_addr !== 13'h005) begin
            failures++; $display("FAIL conflict_rd_mif_wins got gnt=%b addr=%h exp 1/0005", mif_gnt, ram_addr);
        end
        @(negedge clk);
        mif_req = 1'b0;
        #1;
        checks++;
        if (ram_cen !== 1'b0 || ram_addr !== 13'h200 || ram_wen !== 2'b11) begin
            failures++; $display("FAIL conflict_ecc_rd got cen=%b addr=%h wen=%b exp 0/0200/11", ram_cen, ram_addr, ram_wen);
        end
        @(negedge clk);
        mif_req = 1'b1; mif_addr = 13'h006;
        #1;
        checks++;
        if (mif_gnt !== 1'b0 || ram_cen !== 1'b1) begin
            failures++; $display("FAIL conflict_wait_lock got gnt=%b cen=%b exp 0/1", mif_gnt, ram_cen);
        end
        @(negedge clk); #1;
        got = exp_q.pop_front();
        checks++;
        if (mif_gnt !== 1'b0 || ram_wen !== 2'b00 || ram_din !== got) begin
            failures++; $display("FAIL conflict_wr_lock got gnt=%b wen=%b din=%h exp 0/00/%h", mif_gnt, ram_wen, ram_din, got);
        end
        @(negedge clk); #1;
        checks++;
        if (mif_gnt !== 1'b1 || ecc_fix_done !== 1'b1) begin
            failures++; $display("FAIL conflict_done_mif got gnt=%b done=%b exp 1/1", mif_gnt, ecc_fix_done);
        end
        @(negedge clk);
        mif_req = 1'b0; ecc_fix_req = 1'b0;
        #1;
        checks++;
        if (mem[13'h200] !== 16'h7ffe) begin failures++; $display("FAIL conflict_ram got=%h exp=7ffe", mem[13'h200]); end
    endtask

    task automatic test_host_override;
        logic [15:0] got;
        preload(13'h050, 16'hcafe);
        @(negedge clk);
        mif_req = 1'b1; mif_addr = 13'h000; mif_wen = 2'b11;
        hst_req = 1'b1; hst_wr = 1'b0; hst_addr = 13'h050; hst_be = 2'b11;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            checks++;
            if (c < 5) begin
                if (mif_gnt !== 1'b1 || hst_rdy !== 1'b0 || ram_addr !== 13'h000) begin
                    failures++; $display("FAIL ovr_wait cyc=%0d got gnt=%b rdy=%b addr=%h exp 1/0/0000", c, mif_gnt, hst_rdy, ram_addr);
                end
            end else if (c == 5) begin
                exp_q.push_back(16'hcafe);
                if (mif_gnt !== 1'b0 || ram_cen !== 1'b0 || ram_addr !== 13'h050) begin
                    failures++; $display("FAIL ovr_grant got gnt=%b cen=%b addr=%h exp 0/0/0050", mif_gnt, ram_cen, ram_addr);
                end
            end else begin
                got = exp_q.pop_front();
                if (mif_gnt !== 1'b1 || hst_rdy !== 1'b1 || hst_rdat !== got) begin
                    failures++; $display("FAIL ovr_return got gnt=%b rdy=%b rdat=%h exp 1/1/%h", mif_gnt, hst_rdy, hst_rdat, got);
                end
            end
        end
        @(negedge clk);
        mif_req = 1'b0; hst_req = 1'b0;
    endtask

    task automatic test_host_write;
        preload(13'h300, 16'h1234);
        preload(13'h301, 16'h5555);
        @(negedge clk);
        hst_req = 1'b1; hst_wr = 1'b1; hst_addr = 13'h300; hst_be = 2'b10; hst_wdat = 16'hbeef;
        #1;
        checks++;
        if (hst_rdy !== 1'b1 || ram_cen !== 1'b0 || ram_wen !== 2'b01 || ram_din !== 16'hbeef) begin
            failures++; $display("FAIL hst_wr_grant got rdy=%b cen=%b wen=%b din=%h exp 1/0/01/beef", hst_rdy, ram_cen, ram_wen, ram_din);
        end
        @(negedge clk);
        hst_addr = 13'h301; hst_be = 2'b00; hst_wdat = 16'haaaa;
        #1;
        checks++;
        if (hst_rdy !== 1'b1 || ram_cen !== 1'b0 || ram_wen !== 2'b11) begin
            failures++; $display("FAIL hst_wr_no_be got rdy=%b cen=%b wen=%b exp 1/0/11", hst_rdy, ram_cen, ram_wen);
        end
        @(negedge clk);
        hst_req = 1'b0;
        #1;
        checks++;
        if (mem[13'h300] !== 16'hbe34 || mem[13'h301] !== 16'h5555 || hst_rdy !== 1'b0) begin
            failures++; $display("FAIL hst_wr_ram got %h/%h rdy=%b exp be34/5555/0", mem[13'h300], mem[13'h301], hst_rdy);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] got;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            hst_req = 1'b1; hst_wr = 1'b0; hst_addr = 13'(i); hst_be = 2'b11;
            #1;
            checks++;
            if (ram_cen !== 1'b0 || ram_addr !== 13'(i) || hst_rdy !== 1'b0) begin
                failures++; $display("FAIL b2b_grant idx=%0d got cen=%b addr=%h rdy=%b exp 0/%h/0", i, ram_cen, ram_addr, hst_rdy, 13'(i));
            end
            exp_q.push_back(mif_val(i));
            @(negedge clk); #1;
            got = exp_q.pop_front();
            checks++;
            if (hst_rdy !== 1'b1 || hst_rdat !== got || ram_cen !== 1'b1) begin
                failures++; $display("FAIL b2b_return idx=%0d got rdy=%b rdat=%h cen=%b exp 1/%h/1", i, hst_rdy, hst_rdat, ram_cen, got);
            end
        end
        @(negedge clk);
        hst_req = 1'b0;
    endtask

    task automatic test_reset_mid_fix;
        bit found;
        bit bad;
        preload(13'h400, 16'h0f0f);
        @(negedge clk);
        ecc_fix_req = 1'b1; ecc_fix_addr = 13'h400; ecc_fix_mask = 16'h00ff;
        found = 1'b0;
        for (int n = 0; n < 8; n++) begin
            #1;
            if (ram_cen === 1'b0 && ram_addr === 13'h400) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!found) begin failures++; $display("FAIL rstfix_rd_gnt got=none exp=read of 0400"); end
        @(negedge clk);
        rst_n = 1'b0; ecc_fix_req = 1'b0;
        #1;
        checks++;
        if (ram_cen !== 1'b1 || ram_wen !== 2'b11 || ram_addr !== 13'd0 || ecc_fix_done !== 1'b0) begin
            failures++; $display("FAIL rstfix_outputs got cen=%b wen=%b addr=%h done=%b exp 1/11/0000/0", ram_cen, ram_wen, ram_addr, ecc_fix_done);
        end
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            #1;
            if (ecc_fix_done !== 1'b0 || ram_cen !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad || mem[13'h400] !== 16'h0f0f) begin
            failures++; $display("FAIL rstfix_abandon got ram=%h activity=%b exp 0f0f/0", mem[13'h400], bad);
        end
        @(negedge clk);
        ecc_fix_req = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 10; n++) begin
            #1;
            if (ecc_fix_done === 1'b1) begin found = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        ecc_fix_req = 1'b0;
        #1;
        checks++;
        if (!found || mem[13'h400] !== 16'h0ff0) begin
            failures++; $display("FAIL rstfix_reissue got done=%b ram=%h exp 1/0ff0", found, mem[13'h400]);
        end
    endtask

    initial begin
        test_reset();
        test_mif_reads();
        test_ecc_fix();
        test_ecc_mif_conflict();
        test_host_override();
        test_host_write();
        test_back_to_back();
        test_reset_mid_fix();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
